// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal around the memory-port arbiter: the core's
// instruction-fetch (if_*) and load/store (ls_*) request/response channels,
// plus the single read/write port of the RV32I memory block.
//
// Modports:
//   slave  - the arbiter's view. It consumes core requests and memory read
//            data, and produces grants, responses and memory commands.
//   master - the surrounding system's view (core + memory), the mirror image.
//
// Signal summary:
//   if_req / if_addr               IF request, held until if_gnt
//   if_gnt / if_rvalid / if_rdata  IF accept and next-cycle instruction word
//   ls_req / ls_we / ls_funct3 /   LS request, held until ls_gnt
//   ls_addr / ls_wdata
//   ls_gnt / ls_rvalid / ls_rdata  LS accept and next-cycle response
//   ls_err                         misaligned-access flag, qualified by ls_rvalid
//   write_mem / funct3 /           memory command for the current cycle
//   write_address / write_data /
//   read_address
//   read_data                      memory read data, one cycle after read_address
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    // Instruction-fetch channel
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store channel
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    // Memory port
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        input  read_data,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output write_mem, funct3, write_address, write_data, read_address
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        output read_data,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  write_mem, funct3, write_address, write_data, read_address
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Owns the single read port, write port and shared funct3 of the RV32I memory
// block and arbitrates the core's instruction-fetch (IF) and load/store (LS)
// requests onto it, one grant per requester per cycle.
//
//   * LS has priority over IF. A 4-bit streak counter counts consecutive LS
//     grants while IF is waiting; when it reaches MAX_DATA_STREAK, LS is held
//     off for one cycle so the fetch can go through.
//   * An aligned word store may share a cycle with a fetch when they touch
//     different words (funct3 is then 3'b010 for both). Any other LS access
//     takes the port alone.
//   * Misaligned LS accesses are granted but never reach memory; they get an
//     error response (ls_err=1, ls_rdata=0) in the following cycle.
//   * A registered owner tag records who the 1-cycle-latency read belongs to,
//     so read_data is steered to if_rdata or ls_rdata in the next cycle.
//
// Parameters:
//   MAX_DATA_STREAK  consecutive LS grants allowed while IF waits (1..15)
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  asynchronous, active-high reset
//   bus    mem_port_arbiter_if.slave - core request/response channels and
//          the memory port (see the interface file for the signal list)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    // Who owns the read data returning in the next cycle. OWN_ERR marks a
    // misaligned LS access that is answered with an error instead of data.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2,
        OWN_ERR  = 2'd3
    } owner_e;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);
    localparam logic [3:0] STREAK_MAX   = 4'hF;
    localparam logic [2:0] F3_WORD      = 3'b010;

    owner_e      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;

    logic        ls_is_half;
    logic        ls_is_word;
    logic        ls_misaligned;
    logic        ls_blocked;
    logic        share_ok;
    logic        if_gnt;
    logic        ls_gnt;

    // ------------------------------------------------------------------------
    // Request decode and grant decision
    // ------------------------------------------------------------------------
    always_comb begin
        // funct3[1:0] encodes the access size; bit 2 only selects
        // zero-extension on loads and does not affect alignment.
        ls_is_half    = (bus.ls_funct3[1:0] == 2'b01);
        ls_is_word    = (bus.ls_funct3[1:0] == 2'b10);
        ls_misaligned = (ls_is_half && bus.ls_addr[0])
                     || (ls_is_word && (bus.ls_addr[1:0] != 2'b00));

        // Starvation guard: once LS has won STREAK_LIMIT times in a row with
        // IF waiting, LS sits out this cycle.
        ls_blocked = bus.if_req && (streak_q >= STREAK_LIMIT);

        ls_gnt = !reset && bus.ls_req && !ls_blocked;

        // A fetch can ride along with an LS grant only if the LS op is an
        // aligned word store to a different word: the fetch needs funct3=010,
        // and a same-word fetch must wait so it observes the new data.
        share_ok = bus.ls_we
                && (bus.ls_funct3 == F3_WORD)
                && !ls_misaligned
                && (bus.if_addr[31:2] != bus.ls_addr[31:2]);

        if_gnt = !reset && bus.if_req && (!ls_gnt || share_ok);
    end

    // ------------------------------------------------------------------------
    // Memory port command and grant outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output is given a default first so no path through this
        // block leaves a value unassigned, which would infer a latch.
        bus.if_gnt        = if_gnt;
        bus.ls_gnt        = ls_gnt;
        bus.write_mem     = 1'b0;
        bus.funct3        = 3'b000;
        bus.write_address = 32'h0;
        bus.write_data    = 32'h0;
        bus.read_address  = 32'h0;

        if (ls_gnt && !ls_misaligned) begin
            bus.funct3 = bus.ls_funct3;
            if (bus.ls_we) begin
                bus.write_mem     = 1'b1;
                bus.write_address = bus.ls_addr;
                bus.write_data    = bus.ls_wdata;
            end else begin
                bus.read_address = bus.ls_addr;
            end
        end

        // Fetch owns the read port whenever granted; when it shares a cycle
        // with a store that store is a word store, so funct3=010 suits both.
        if (if_gnt) begin
            bus.read_address = bus.if_addr;
            bus.funct3       = F3_WORD;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: owner tag and starvation streak
    // ------------------------------------------------------------------------
    always_comb begin
        owner_d  = OWN_NONE;
        streak_d = streak_q;

        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt) begin
            if (ls_misaligned) begin
                owner_d = OWN_ERR;
            end else if (!bus.ls_we) begin
                owner_d = OWN_LS;
            end
            // Aligned stores return nothing, so the tag stays OWN_NONE.
        end

        // The streak only measures how long a waiting fetch has been passed
        // over, so it restarts whenever IF is served or stops asking.
        if (!bus.if_req || if_gnt) begin
            streak_d = 4'd0;
        end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of the order in which blocks execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            streak_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response routing, one cycle after the grant
    // ------------------------------------------------------------------------
    // Reset forces owner_q to OWN_NONE, so an in-flight response is dropped
    // and every response output is 0 while reset is held.
    always_comb begin
        bus.if_rvalid = (owner_q == OWN_IF);
        bus.if_rdata  = (owner_q == OWN_IF) ? bus.read_data : 32'h0;
        bus.ls_rvalid = (owner_q == OWN_LS) || (owner_q == OWN_ERR);
        bus.ls_err    = (owner_q == OWN_ERR);
        bus.ls_rdata  = (owner_q == OWN_LS) ? bus.read_data : 32'h0;
    end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with MAX_DATA_STREAK=4. A small
// behavioural RV32I memory answers the arbiter's port with 1-cycle read
// latency. Its initial contents are word-addressed: the word at aligned byte
// address A reads as 32'hC0DE_0000 | A, stored little-endian. Bytes written
// by stores are kept in an overlay.
//
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ------------------------------------------------------------------------
    // Behavioural memory
    // ------------------------------------------------------------------------
    logic [7:0]  written [int];
    logic [31:0] rd_q = 32'h0;

    assign bus.read_data = rd_q;

    function automatic logic [7:0] byte_at(input logic [11:0] idx);
        logic [31:0] word;
        if (written.exists(int'(idx))) begin
            return written[int'(idx)];
        end
        word = 32'hC0DE_0000 | {20'h0, idx[11:2], 2'b00};
        return word[8 * int'(idx[1:0]) +: 8];
    endfunction

    function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] b0, b1, b2, b3;
        b0 = byte_at(a[11:0]);
        b1 = byte_at(a[11:0] + 12'd1);
        b2 = byte_at(a[11:0] + 12'd2);
        b3 = byte_at(a[11:0] + 12'd3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        rd_q <= mem_load(bus.read_address, bus.funct3);
        if (bus.write_mem) begin
            written[int'(bus.write_address[11:0])] = bus.write_data[7:0];
            if (bus.funct3[1:0] != 2'b00) begin
                written[int'(bus.write_address[11:0] + 12'd1)] = bus.write_data[15:8];
            end
            if (bus.funct3[1:0] == 2'b10) begin
                written[int'(bus.write_address[11:0] + 12'd2)] = bus.write_data[23:16];
                written[int'(bus.write_address[11:0] + 12'd3)] = bus.write_data[31:24];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_funct3 = 3'b000;
        bus.ls_addr   = 32'h0;
        bus.ls_wdata  = 32'h0;
    endtask

    task automatic set_if(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
    endtask

    task automatic set_ls(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.ls_req    = 1'b1;
        bus.ls_we     = we;
        bus.ls_funct3 = f3;
        bus.ls_addr   = addr;
        bus.ls_wdata  = wdata;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [7:0] exp_ls;

        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();

        // Requests while reset is high must not be granted; outputs all 0.
        set_if(32'h40);
        set_ls(1'b0, 3'b010, 32'h44, 32'h0);
        sample();
        check("rst_if_gnt",    32'(bus.if_gnt), 0);
        check("rst_ls_gnt",    32'(bus.ls_gnt), 0);
        check("rst_write_mem", 32'(bus.write_mem), 0);
        check("rst_read_addr", bus.read_address, 0);
        check("rst_funct3",    32'(bus.funct3), 0);
        check("rst_if_rvalid", 32'(bus.if_rvalid), 0);
        check("rst_ls_rvalid", 32'(bus.ls_rvalid), 0);
        check("rst_ls_err",    32'(bus.ls_err), 0);

        next_cycle();
        reset = 1'b0;
        clear_inputs();
        sample();
        check("idle_if_gnt", 32'(bus.if_gnt), 0);

        // Lone IF stream 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_if(32'(i * 4));
            sample();
            check("ifs_gnt",   32'(bus.if_gnt), 1);
            check("ifs_raddr", bus.read_address, 32'(i * 4));
            check("ifs_f3",    32'(bus.funct3), 2);
            check("ifs_rvalid", 32'(bus.if_rvalid), (i > 0) ? 1 : 0);
            if (i > 0) begin
                check("ifs_rdata", bus.if_rdata, 32'hC0DE_0000 | 32'((i - 1) * 4));
            end
        end
        next_cycle();
        clear_inputs();
        sample();
        check("ifs_last_gnt",    32'(bus.if_gnt), 0);
        check("ifs_last_rvalid", 32'(bus.if_rvalid), 1);
        check("ifs_last_rdata",  bus.if_rdata, 32'hC0DE_0008);

        // LS priority with starvation bound: LS,LS,LS,LS,IF,LS,LS,LS.
        exp_ls = 8'b1110_1111;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (i == 0) begin
                set_if(32'h10);
                set_ls(1'b0, 3'b010, 32'h20, 32'h0);
            end
            sample();
            check("stv_ls_gnt", 32'(bus.ls_gnt), 32'(exp_ls[i]));
            check("stv_if_gnt", 32'(bus.if_gnt), 32'(!exp_ls[i]));
            if (i > 0) begin
                check("stv_ls_rvalid", 32'(bus.ls_rvalid), 32'(exp_ls[i - 1]));
                check("stv_if_rvalid", 32'(bus.if_rvalid), 32'(!exp_ls[i - 1]));
                if (exp_ls[i - 1]) begin
                    check("stv_ls_rdata", bus.ls_rdata, 32'hC0DE_0020);
                end else begin
                    check("stv_if_rdata", bus.if_rdata, 32'hC0DE_0010);
                end
            end
        end
        next_cycle();
        clear_inputs();
        sample();
        check("stv_tail_rvalid", 32'(bus.ls_rvalid), 1);
        check("stv_tail_rdata",  bus.ls_rdata, 32'hC0DE_0020);

        // Word store 0x100 plus fetch 0x200: both granted together.
        next_cycle();
        set_ls(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        set_if(32'h200);
        sample();
        check("cc_ls_gnt",  32'(bus.ls_gnt), 1);
        check("cc_if_gnt",  32'(bus.if_gnt), 1);
        check("cc_wmem",    32'(bus.write_mem), 1);
        check("cc_waddr",   bus.write_address, 32'h100);
        check("cc_wdata",   bus.write_data, 32'hDEAD_BEEF);
        check("cc_raddr",   bus.read_address, 32'h200);
        check("cc_f3",      32'(bus.funct3), 2);

        // Same-word fetch 0x100 alongside the store: fetch must wait.
        next_cycle();
        set_if(32'h100);
        sample();
        check("cc_if_rvalid", 32'(bus.if_rvalid), 1);
        check("cc_if_rdata",  bus.if_rdata, 32'hC0DE_0200);
        check("cc_st_rvalid", 32'(bus.ls_rvalid), 0);
        check("sa_ls_gnt",    32'(bus.ls_gnt), 1);
        check("sa_if_gnt",    32'(bus.if_gnt), 0);
        check("sa_raddr",     bus.read_address, 0);

        next_cycle();
        bus.ls_req = 1'b0;
        sample();
        check("sa_if_gnt2",  32'(bus.if_gnt), 1);
        check("sa_raddr2",   bus.read_address, 32'h100);

        // sb 0x101 with a pending fetch: fetch not granted.
        next_cycle();
        set_ls(1'b1, 3'b000, 32'h101, 32'h0000_00EF);
        set_if(32'h300);
        sample();
        check("sa_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        check("sb_ls_gnt",   32'(bus.ls_gnt), 1);
        check("sb_if_gnt",   32'(bus.if_gnt), 0);
        check("sb_wmem",     32'(bus.write_mem), 1);
        check("sb_f3",       32'(bus.funct3), 0);

        // lbu 0x101 reads back the stored byte.
        next_cycle();
        set_ls(1'b0, 3'b100, 32'h101, 32'h0);
        sample();
        check("lbu_ls_gnt", 32'(bus.ls_gnt), 1);
        check("lbu_if_gnt", 32'(bus.if_gnt), 0);
        check("lbu_raddr",  bus.read_address, 32'h101);
        check("lbu_f3",     32'(bus.funct3), 4);

        next_cycle();
        bus.ls_req = 1'b0;
        sample();
        check("lbu_rvalid", 32'(bus.ls_rvalid), 1);
        check("lbu_rdata",  bus.ls_rdata, 32'h0000_00EF);
        check("lbu_err",    32'(bus.ls_err), 0);
        check("sb_if_gnt2", 32'(bus.if_gnt), 1);
        check("sb_raddr2",  bus.read_address, 32'h300);

        next_cycle();
        clear_inputs();
        sample();
        check("sb_if_rdata", bus.if_rdata, 32'hC0DE_0300);

        // Misaligned lw 0x102 then sh 0x103: no memory access, error response.
        next_cycle();
        set_ls(1'b0, 3'b010, 32'h102, 32'h0);
        sample();
        check("mis_lw_gnt",   32'(bus.ls_gnt), 1);
        check("mis_lw_raddr", bus.read_address, 0);
        check("mis_lw_wmem",  32'(bus.write_mem), 0);

        next_cycle();
        set_ls(1'b1, 3'b001, 32'h103, 32'h0000_1234);
        sample();
        check("mis_lw_rvalid", 32'(bus.ls_rvalid), 1);
        check("mis_lw_err",    32'(bus.ls_err), 1);
        check("mis_lw_rdata",  bus.ls_rdata, 0);
        check("mis_sh_gnt",    32'(bus.ls_gnt), 1);
        check("mis_sh_wmem",   32'(bus.write_mem), 0);

        // lhu 0x102 confirms the misaligned sh left memory untouched.
        next_cycle();
        set_ls(1'b0, 3'b101, 32'h102, 32'h0);
        sample();
        check("mis_sh_rvalid", 32'(bus.ls_rvalid), 1);
        check("mis_sh_err",    32'(bus.ls_err), 1);
        check("mis_sh_rdata",  bus.ls_rdata, 0);
        check("lhu_raddr",     bus.read_address, 32'h102);

        // Load grant, then reset in the following cycle drops its response.
        next_cycle();
        set_ls(1'b0, 3'b010, 32'h100, 32'h0);
        sample();
        check("lhu_rvalid", 32'(bus.ls_rvalid), 1);
        check("lhu_err",    32'(bus.ls_err), 0);
        check("lhu_rdata",  bus.ls_rdata, 32'h0000_DEAD);
        check("rmf_ls_gnt", 32'(bus.ls_gnt), 1);

        next_cycle();
        clear_inputs();
        reset = 1'b1;
        sample();
        check("rmf_rvalid0", 32'(bus.ls_rvalid), 0);
        check("rmf_rdata0",  bus.ls_rdata, 0);

        next_cycle();
        sample();
        check("rmf_rvalid1", 32'(bus.ls_rvalid), 0);

        next_cycle();
        reset = 1'b0;
        set_if(32'h0);
        sample();
        check("rmf_rvalid2",   32'(bus.ls_rvalid), 0);
        check("rmf_if_rvalid", 32'(bus.if_rvalid), 0);
        check("rmf_ls_err",    32'(bus.ls_err), 0);
        check("rmf_if_gnt",    32'(bus.if_gnt), 1);
        check("rmf_wmem",      32'(bus.write_mem), 0);

        next_cycle();
        clear_inputs();
        sample();
        check("rmf_if_rvalid2", 32'(bus.if_rvalid), 1);
        check("rmf_if_rdata",   bus.if_rdata, 32'hC0DE_0000);
        check("rmf_ls_rvalid3", 32'(bus.ls_rvalid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
